adder32_seq: RTL



---
 rtl/adder32_seq_pkg.sv | 13 +
 rtl/adder32_seq_if.sv | 26 ++
 rtl/adder32_seq_slice.sv | 42 ++++
 rtl/adder32_seq.sv | 119 +++++++++++
 4 files changed

// File: rtl/adder32_seq_pkg.sv
// Shared definitions for the byte-serial adder: default widths and FSM encoding.
package adder32_seq_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder32_seq_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface adder32_seq_if import adder32_seq_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output start, a, b, c_in,
      input  busy, done, sum, c_out, ovf
   );

   modport slave (
      input  start, a, b, c_in,
      output busy, done, sum, c_out, ovf
   );

endinterface

// File: rtl/adder32_seq_slice.sv
// Full-adder cell and the W-bit ripple-carry slice reused by the serial controller.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module adder_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic [W-1:0] sum,
   output logic         c_out
);

   // carry[i] enters bit i; carry[W] leaves the slice
   logic [W:0] carry;

   assign carry[0] = c_in;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      full_adder u_fa (
         .a     (a[gi]),
         .b     (b[gi]),
         .c_in  (carry[gi]),
         .sum   (sum[gi]),
         .c_out (carry[gi+1])
      );
   end

   assign c_out = carry[W];

endmodule

// File: rtl/adder32_seq.sv
// Byte-serial adder controller: one shared SLICE-bit adder walks the operands
// LSB slice first, chaining the carry through a register, then pulses done.
module adder32_seq import adder32_seq_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic         clk,
   input  logic         rst_n,
   adder32_seq_if.slave bus
);

   localparam int NUM   = WIDTH / SLICE;
   localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               c_out_q, c_out_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, done_q;

   // Captured operands viewed as an array of slices so the shared adder can
   // be fed through a plain index mux.
   logic [SLICE-1:0]   a_sl [NUM];
   logic [SLICE-1:0]   b_sl [NUM];
   logic [SLICE-1:0]   slice_s;
   logic               slice_cy;

   for (genvar gi = 0; gi < NUM; gi++) begin : g_split
      assign a_sl[gi] = op_a_q[gi*SLICE +: SLICE];
      assign b_sl[gi] = op_b_q[gi*SLICE +: SLICE];
   end

   adder_slice #(.W(SLICE)) u_slice (
      .a     (a_sl[idx_q]),
      .b     (b_sl[idx_q]),
      .c_in  (carry_q),
      .sum   (slice_s),
      .c_out (slice_cy)
   );

   // Next-state: capture in IDLE, one slice per RUN cycle, single DONE cycle.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_a_d  = bus.a;
               op_b_d  = bus.b;
               carry_d = bus.c_in;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < NUM; i++) begin
               if (idx_q == IDX_W'(i)) sum_d[i*SLICE +: SLICE] = slice_s;
            end
            carry_d = slice_cy;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               // Overflow only when like-signed operands yield a result of the other sign
               c_out_d = slice_cy;
               ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                         (slice_s[SLICE-1] != op_a_q[WIDTH-1]);
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; busy/done are registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;
   assign bus.ovf   = ovf_q;

endmodule
